// File: rtl/sort_scheduler.sv
// Bubble-sort controller: owns the raw entry buffer and the working/sorted buffer,
// and drives one compare-and-swap per cycle over an N-entry buffer.
module sort_scheduler #(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write,
  input  logic [IDX_W-1:0] sel,
  input  logic [W-1:0]     num,
  input  logic             start,
  input  logic             descend,
  input  logic [IDX_W-1:0] rd_sel,
  input  logic             show_sorted,
  output logic [W-1:0]     rd_data,
  output logic             busy,
  output logic             done,
  output logic             sorted_valid,
  output logic             write_err
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPARE, PASS_END} state_t;

  state_t           state;
  logic [W-1:0]     raw    [N];
  logic [W-1:0]     sorted [N];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pass;
  logic             swapped;
  logic             order;

  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] last_idx;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_of_order;
  logic             sel_ok;

  assign idx_nx       = idx + 1'b1;
  assign last_idx     = IDX_W'(N - 2) - pass;
  assign a            = sorted[idx];
  assign b            = sorted[idx_nx];
  // Strict compares keep equal values in place, so the sort is stable.
  assign out_of_order = order ? (a < b) : (a > b);
  assign sel_ok       = int'(sel) < N;

  always_comb begin
    rd_data = '0;
    if (int'(rd_sel) < N)
      rd_data = show_sorted ? sorted[rd_sel] : raw[rd_sel];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      pass         <= '0;
      swapped      <= 1'b0;
      order        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sorted_valid <= 1'b0;
      write_err    <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        raw[i]    <= '0;
        sorted[i] <= '0;
      end
    end else begin
      done      <= 1'b0;
      write_err <= 1'b0;
      if (state != IDLE && write)
        write_err <= 1'b1;
      case (state)
        IDLE: begin
          if (write && sel_ok) begin
            raw[sel]     <= num;
            sorted_valid <= 1'b0;
          end
          if (start) begin
            order <= descend;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          for (int unsigned i = 0; i < N; i++)
            sorted[i] <= raw[i];
          idx     <= '0;
          pass    <= '0;
          swapped <= 1'b0;
          state   <= COMPARE;
        end
        COMPARE: begin
          if (out_of_order) begin
            sorted[idx]    <= b;
            sorted[idx_nx] <= a;
            swapped        <= 1'b1;
          end
          if (idx == last_idx)
            state <= PASS_END;
          else
            idx <= idx_nx;
        end
        PASS_END: begin
          if (!swapped || pass == IDX_W'(N - 2)) begin
            done         <= 1'b1;
            sorted_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            pass    <= pass + 1'b1;
            idx     <= '0;
            swapped <= 1'b0;
            state   <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_scheduler.sv
// Scoreboard bench for sort_scheduler: stimulus queues expected sort results,
// a monitor checks latency and both buffers on every done pulse and every reset.
module tb_sort_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       write;
  logic [1:0] sel;
  logic [3:0] num;
  logic       start;
  logic       descend;
  logic [1:0] rd_sel;
  logic       show_sorted;
  logic [3:0] rd_data;
  logic       busy;
  logic       done;
  logic       sorted_valid;
  logic       write_err;

  sort_scheduler #(.N(4), .W(4), .IDX_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .write       (write),
    .sel         (sel),
    .num         (num),
    .start       (start),
    .descend     (descend),
    .rd_sel      (rd_sel),
    .show_sorted (show_sorted),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .sorted_valid(sorted_valid),
    .write_err   (write_err)
  );

  always #20 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_rst;
    int          start_cyc;
    int          lat;
    logic [15:0] raw;
    logic [15:0] srt;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // entry 0 is the first argument and lands in bits [3:0]
  function automatic logic [15:0] pk(input logic [3:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic rd_all(input string tag, input logic [15:0] er, input logic [15:0] es);
    for (int i = 0; i < 4; i++) begin
      rd_sel      = 2'(i);
      show_sorted = 1'b0;
      #1 chk($sformatf("%s raw[%0d]", tag, i), rd_data, er[4*i +: 4]);
      show_sorted = 1'b1;
      #1 chk($sformatf("%s sorted[%0d]", tag, i), rd_data, es[4*i +: 4]);
    end
  endtask

  // Monitor: consumes one scoreboard entry per reset assertion or done pulse.
  bit rst_seen = 1'b0;
  initial begin
    item_t it;
    rd_sel      = '0;
    show_sorted = 1'b0;
    forever begin
      @(negedge clock or posedge reset);
      if (reset && !rst_seen) begin
        rst_seen = 1'b1;
        #1;
        if (sb.size() == 0 || !sb[0].is_rst) begin
          checks++; errors++;
          $display("FAIL unexpected reset: got reset expected none queued");
        end else begin
          it = sb.pop_front();
          rd_all("reset", 16'h0, 16'h0);
        end
      end else if (!reset) begin
        rst_seen = 1'b0;
        if (done) begin
          if (sb.size() == 0 || sb[0].is_rst) begin
            checks++; errors++;
            $display("FAIL unexpected done: got done=1 expected no sort pending");
          end else begin
            it = sb.pop_front();
            chk("done latency", cyc - it.start_cyc, it.lat);
            chk("sorted_valid at done", sorted_valid, 1);
            chk("busy at done", busy, 0);
            rd_all($sformatf("sort@%0d", it.start_cyc), it.raw, it.srt);
          end
        end
      end
    end
  end

  task automatic wr(input logic [1:0] s, input logic [3:0] v);
    write = 1'b1;
    sel   = s;
    num   = v;
    @(posedge clock);
    #1 write = 1'b0;
  endtask

  task automatic wr4(input logic [15:0] v);
    for (int i = 0; i < 4; i++) wr(2'(i), v[4*i +: 4]);
  endtask

  // Raises start for the sampling edge; write is cleared with it so a
  // same-cycle write can be staged by the caller.
  task automatic do_start(input bit d, input bit expect_done,
                          input logic [15:0] er, input logic [15:0] es, input int lat);
    item_t it;
    start   = 1'b1;
    descend = d;
    @(posedge clock);
    #1;
    start = 1'b0;
    write = 1'b0;
    if (expect_done) begin
      it.is_rst    = 1'b0;
      it.start_cyc = cyc;
      it.lat       = lat;
      it.raw       = er;
      it.srt       = es;
      sb.push_back(it);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    chk({name, " done seen"}, done, 1);
  endtask

  task automatic push_rst();
    item_t it;
    it.is_rst    = 1'b1;
    it.start_cyc = 0;
    it.lat       = 0;
    it.raw       = '0;
    it.srt       = '0;
    sb.push_back(it);
  endtask

  initial begin
    int n;
    reset = 1'b0; write = 1'b0; sel = '0; num = '0; start = 1'b0; descend = 1'b0;
    push_rst();
    #3 reset = 1'b1;
    #5;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sorted_valid", sorted_valid, 0);
    chk("reset write_err", write_err, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // reversed input: worst-case latency, busy high for exactly 10 cycles
    wr4(pk(3, 2, 1, 0));
    do_start(0, 1, pk(3, 2, 1, 0), pk(0, 1, 2, 3), 10);
    n = 0;
    @(negedge clock);
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("t1 busy cycles", n, 10);
    chk("t1 done as busy falls", done, 1);

    // already sorted: single pass
    wr4(pk(1, 2, 3, 4));
    do_start(0, 1, pk(1, 2, 3, 4), pk(1, 2, 3, 4), 5);
    wait_done("t2");

    // descending with duplicates, then a write drops sorted_valid
    wr4(pk(5, 5, 2, 4'hF));
    do_start(1, 1, pk(5, 5, 2, 4'hF), pk(4'hF, 5, 5, 2), 10);
    wait_done("t3");
    @(negedge clock);
    chk("t3 done one cycle", done, 0);
    chk("t3 sorted_valid held", sorted_valid, 1);
    wr(2'd0, 4'd7);
    @(negedge clock);
    chk("t3 sorted_valid after write", sorted_valid, 0);

    // writes while busy are rejected and flagged every cycle
    wr4(pk(9, 8, 7, 6));
    do_start(0, 1, pk(9, 8, 7, 6), pk(6, 7, 8, 9), 10);
    @(negedge clock);
    chk("t4 write_err idle", write_err, 0);
    write = 1'b1; sel = 2'd1; num = 4'hA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("t4 write_err busy %0d", k), write_err, 1);
    end
    write = 1'b0;
    @(negedge clock);
    chk("t4 write_err released", write_err, 0);
    wait_done("t4");

    // write in the start cycle is seen by LOAD
    wr4(pk(4, 3, 9, 1));
    @(negedge clock);
    write = 1'b1; sel = 2'd2; num = 4'd0;
    do_start(0, 1, pk(4, 3, 0, 1), pk(0, 1, 3, 4), 10);
    wait_done("t5");

    // one swap then a clean pass terminates early
    wr4(pk(2, 1, 3, 4));
    do_start(0, 1, pk(2, 1, 3, 4), pk(1, 2, 3, 4), 8);
    wait_done("t6");

    // async reset mid-sort
    wr4(pk(3, 1, 2, 0));
    do_start(0, 0, '0, '0, 0);
    repeat (3) @(posedge clock);
    #1 push_rst();
    #1 reset = 1'b1;
    #1;
    chk("t7 busy after reset", busy, 0);
    chk("t7 done after reset", done, 0);
    chk("t7 sorted_valid after reset", sorted_valid, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (12) @(negedge clock);
    chk("t7 stays idle", busy, 0);

    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
